// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command arbiter: FSM states and SDRAM command codes.
package sdram_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } state_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AREF      = 4'b0001;
  localparam logic [3:0] CMD_MRS       = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_READ      = 4'b0101;

  localparam logic [1:0] NOP_BA = 2'b11;

endpackage

// File: rtl/sdram_arbit_if.sv
// Request/grant handshakes and command buses between the refresh/write/read engines and the arbiter.
interface sdram_arbit_if #(
  parameter int ADDR_W = 12
) ();

  logic              aref_req;
  logic              aref_end;
  logic              aref_en;
  logic [3:0]        aref_cmd;
  logic [1:0]        aref_ba;
  logic [ADDR_W-1:0] aref_addr;

  logic              wr_req;
  logic              wr_end;
  logic              wr_en;
  logic [3:0]        wr_cmd;
  logic [1:0]        wr_ba;
  logic [ADDR_W-1:0] wr_addr;

  logic              rd_req;
  logic              rd_end;
  logic              rd_en;
  logic [3:0]        rd_cmd;
  logic [1:0]        rd_ba;
  logic [ADDR_W-1:0] rd_addr;

  modport master (
    output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
    output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    input  aref_en, wr_en, rd_en
  );

  modport slave (
    input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
    input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    output aref_en, wr_en, rd_en
  );

endinterface

// File: rtl/sdram_arbit.sv
// Arbitrates the SDRAM command bus between init, auto-refresh, write and read engines.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DQ_W   = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  sdram_arbit_if.slave      arb,
  input  logic [DQ_W-1:0]   wr_data,
  input  logic              wr_sdram_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DQ_W-1:0]   sdram_dq
);

  state_t state, state_nxt;
  logic   last_wr, last_wr_nxt;
  logic [3:0] cmd;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= ST_INIT;
      last_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      last_wr <= last_wr_nxt;
    end
  end

  // Refresh always wins; a write/read tie goes to whichever was not served last.
  always_comb begin
    state_nxt   = state;
    last_wr_nxt = last_wr;
    case (state)
      ST_INIT: if (init_end) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (arb.aref_req) begin
          state_nxt = ST_AREF;
        end else if (arb.wr_req && (!arb.rd_req || !last_wr)) begin
          state_nxt   = ST_WRITE;
          last_wr_nxt = 1'b1;
        end else if (arb.rd_req) begin
          state_nxt   = ST_READ;
          last_wr_nxt = 1'b0;
        end
      end
      ST_AREF:  if (arb.aref_end) state_nxt = ST_IDLE;
      ST_WRITE: if (arb.wr_end)   state_nxt = ST_IDLE;
      ST_READ:  if (arb.rd_end)   state_nxt = ST_IDLE;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    arb.aref_en = (state == ST_AREF);
    arb.wr_en   = (state == ST_WRITE);
    arb.rd_en   = (state == ST_READ);
    cmd         = CMD_NOP;
    sdram_ba    = NOP_BA;
    sdram_addr  = '1;
    case (state)
      ST_INIT: begin
        cmd        = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        cmd        = arb.aref_cmd;
        sdram_ba   = arb.aref_ba;
        sdram_addr = arb.aref_addr;
      end
      ST_WRITE: begin
        cmd        = arb.wr_cmd;
        sdram_ba   = arb.wr_ba;
        sdram_addr = arb.wr_addr;
      end
      ST_READ: begin
        cmd        = arb.rd_cmd;
        sdram_ba   = arb.rd_ba;
        sdram_addr = arb.rd_addr;
      end
      default: ;
    endcase
    {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    sdram_cke = 1'b1;
  end

  assign sdram_dq = (state == ST_WRITE && wr_sdram_en) ? wr_data : 'z;

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboard bench for sdram_arbit: directed scenarios followed by randomized traffic.
module tb_sdram_arbit;

  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          init_end;
  logic [3:0]    init_cmd;
  logic [1:0]    init_ba;
  logic [AW-1:0] init_addr;
  logic [DW-1:0] wr_data;
  logic          wr_sdram_en;

  wire           cke, cs_n, ras_n, cas_n, we_n;
  wire [1:0]     ba;
  wire [AW-1:0]  addr;
  wire [DW-1:0]  dq;

  // The bench drives a known pattern whenever the arbiter must leave dq floating,
  // so a spurious DUT driver shows up as a corrupted read-back.
  logic          tb_drv;
  logic [DW-1:0] tb_pat;
  assign dq = tb_drv ? tb_pat : 'z;

  sdram_arbit_if #(.ADDR_W(AW)) arb ();

  sdram_arbit #(.ADDR_W(AW), .DQ_W(DW)) dut (
    .sys_clk     (clk),
    .sys_rst     (rst),
    .init_end    (init_end),
    .init_cmd    (init_cmd),
    .init_ba     (init_ba),
    .init_addr   (init_addr),
    .arb         (arb),
    .wr_data     (wr_data),
    .wr_sdram_en (wr_sdram_en),
    .sdram_cke   (cke),
    .sdram_cs_n  (cs_n),
    .sdram_ras_n (ras_n),
    .sdram_cas_n (cas_n),
    .sdram_we_n  (we_n),
    .sdram_ba    (ba),
    .sdram_addr  (addr),
    .sdram_dq    (dq)
  );

  typedef struct packed {
    logic [2:0]    gnt;   // {aref_en, wr_en, rd_en}
    logic          cke;
    logic [3:0]    cmd;
    logic [1:0]    ba;
    logic [AW-1:0] addr;
    logic [DW-1:0] dq;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: who currently owns the bus, and whether write was served last.
  typedef enum {M_INIT, M_IDLE, M_AREF, M_WR, M_RD} owner_t;
  owner_t owner;
  bit     wr_served_last;
  bit     fix_data;

  task automatic step();
    obs_t e;
    bit   dut_drives;
    init_cmd      = 4'($urandom);
    init_ba       = 2'($urandom);
    init_addr     = AW'($urandom);
    arb.aref_cmd  = 4'($urandom);
    arb.aref_ba   = 2'($urandom);
    arb.aref_addr = AW'($urandom);
    arb.wr_cmd    = 4'($urandom);
    arb.wr_ba     = 2'($urandom);
    arb.wr_addr   = AW'($urandom);
    arb.rd_cmd    = 4'($urandom);
    arb.rd_ba     = 2'($urandom);
    arb.rd_addr   = AW'($urandom);
    if (!fix_data) wr_data = DW'($urandom);
    tb_pat = DW'($urandom);

    e.cke = 1'b1;
    e.gnt = 3'b000;
    case (owner)
      M_INIT: begin e.cmd = init_cmd; e.ba = init_ba; e.addr = init_addr; end
      M_IDLE: begin e.cmd = 4'b0111; e.ba = 2'b11; e.addr = {AW{1'b1}}; end
      M_AREF: begin e.gnt = 3'b100; e.cmd = arb.aref_cmd; e.ba = arb.aref_ba; e.addr = arb.aref_addr; end
      M_WR:   begin e.gnt = 3'b010; e.cmd = arb.wr_cmd; e.ba = arb.wr_ba; e.addr = arb.wr_addr; end
      M_RD:   begin e.gnt = 3'b001; e.cmd = arb.rd_cmd; e.ba = arb.rd_ba; e.addr = arb.rd_addr; end
    endcase
    dut_drives = (owner == M_WR) && wr_sdram_en;
    tb_drv     = !dut_drives;
    e.dq       = dut_drives ? wr_data : tb_pat;
    exp_q.push_back(e);

    @(posedge clk);
    if (rst) begin
      owner          = M_INIT;
      wr_served_last = 1'b0;
    end else begin
      case (owner)
        M_INIT: if (init_end) owner = M_IDLE;
        M_IDLE: begin
          if (arb.aref_req) owner = M_AREF;
          else if (arb.wr_req && arb.rd_req) owner = wr_served_last ? M_RD : M_WR;
          else if (arb.wr_req) owner = M_WR;
          else if (arb.rd_req) owner = M_RD;
          if (owner == M_WR) wr_served_last = 1'b1;
          if (owner == M_RD) wr_served_last = 1'b0;
        end
        M_AREF: if (arb.aref_end) owner = M_IDLE;
        M_WR:   if (arb.wr_end)   owner = M_IDLE;
        M_RD:   if (arb.rd_end)   owner = M_IDLE;
      endcase
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_end(input int which);
    if (which == 0) arb.aref_end = 1'b1;
    if (which == 1) arb.wr_end   = 1'b1;
    if (which == 2) arb.rd_end   = 1'b1;
    step();
    arb.aref_end = 1'b0;
    arb.wr_end   = 1'b0;
    arb.rd_end   = 1'b0;
  endtask

  task automatic run_until(input owner_t target);
    int n = 0;
    while (owner != target && n < 30) begin
      step();
      n++;
    end
    total++;
    if (owner != target) begin
      bad++;
      $display("FAIL reach_state: model state %0d, required %0d", owner, target);
    end
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{gnt: {arb.aref_en, arb.wr_en, arb.rd_en}, cke: cke,
              cmd: {cs_n, ras_n, cas_n, we_n}, ba: ba, addr: addr, dq: dq};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL pins @%0t: got gnt=%b cke=%b cmd=%b ba=%b addr=%h dq=%h, need gnt=%b cke=%b cmd=%b ba=%b addr=%h dq=%h",
                   $time, a.gnt, a.cke, a.cmd, a.ba, a.addr, a.dq,
                   e.gnt, e.cke, e.cmd, e.ba, e.addr, e.dq);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1; init_end = 1'b0; wr_sdram_en = 1'b0; wr_data = '0;
    tb_drv = 1'b1; tb_pat = '0; fix_data = 1'b0;
    arb.aref_req = 1'b0; arb.aref_end = 1'b0;
    arb.wr_req   = 1'b0; arb.wr_end   = 1'b0;
    arb.rd_req   = 1'b0; arb.rd_end   = 1'b0;
    owner = M_INIT; wr_served_last = 1'b0;
    @(posedge clk); #1;

    // Reset, then init sequence held for 10 cycles before init_end.
    steps(3);
    rst = 1'b0;
    steps(10);
    init_end = 1'b1;
    steps(3);

    // All three requests together: refresh first, then write after one IDLE cycle.
    arb.aref_req = 1'b1; arb.wr_req = 1'b1; arb.rd_req = 1'b1;
    step();
    arb.aref_req = 1'b0;
    steps(3);
    pulse_end(0);
    step();
    steps(2);
    pulse_end(1);

    // Continuous write+read demand alternates grants.
    for (int g = 0; g < 4; g++) begin
      int n = 0;
      while (owner != M_WR && owner != M_RD && n < 5) begin step(); n++; end
      steps(7);
      pulse_end(owner == M_WR ? 1 : 2);
    end
    arb.wr_req = 1'b0; arb.rd_req = 1'b0;
    steps(2);

    // Data bus: drive A5A5 only while writing with wr_sdram_en.
    fix_data = 1'b1; wr_data = 16'hA5A5;
    arb.wr_req = 1'b1;
    run_until(M_WR);
    arb.wr_req = 1'b0;
    wr_sdram_en = 1'b1; steps(3);
    wr_sdram_en = 1'b0; steps(2);
    wr_sdram_en = 1'b1; pulse_end(1);
    arb.rd_req = 1'b1;
    run_until(M_RD);
    arb.rd_req = 1'b0;
    steps(4);

    // Reset in the middle of a read burst, then a stray rd_end in IDLE.
    rst = 1'b1; step();
    rst = 1'b0; steps(2);
    arb.rd_end = 1'b1; steps(2); arb.rd_end = 1'b0;
    wr_sdram_en = 1'b0; fix_data = 1'b0;
    arb.wr_req = 1'b1; arb.rd_req = 1'b1;
    step();
    arb.wr_req = 1'b0; arb.rd_req = 1'b0;
    steps(3);
    pulse_end(1);

    // Randomized traffic, including stray end pulses and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      rst          = ($urandom_range(0, 127) == 0);
      init_end     = ($urandom_range(0, 3) != 0);
      arb.aref_req = ($urandom_range(0, 5) == 0);
      arb.wr_req   = ($urandom_range(0, 2) == 0);
      arb.rd_req   = ($urandom_range(0, 2) == 0);
      arb.aref_end = ($urandom_range(0, 4) == 0);
      arb.wr_end   = ($urandom_range(0, 4) == 0);
      arb.rd_end   = ($urandom_range(0, 4) == 0);
      wr_sdram_en  = $urandom_range(0, 1) == 1;
      step();
    end

    @(negedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, need 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
